// File: rtl/sdes_pkg.sv
// sdes_pkg: shared S-DES permutation tables, S-boxes, decrypt FSM states and permutation helpers
package sdes_pkg;
    localparam int P10_T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam int P8_T  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
    localparam int IP_T  [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
    localparam int IPI_T [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
    localparam int EP_T  [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
    localparam int P4_T  [4]  = '{2, 4, 3, 1};
    localparam logic [1:0] S0 [4][4] = '{'{2'd1, 2'd0, 2'd3, 2'd2}, '{2'd3, 2'd2, 2'd1, 2'd0},
                                         '{2'd0, 2'd2, 2'd1, 2'd3}, '{2'd3, 2'd1, 2'd3, 2'd2}};
    localparam logic [1:0] S1 [4][4] = '{'{2'd0, 2'd1, 2'd2, 2'd3}, '{2'd2, 2'd0, 2'd1, 2'd3},
                                         '{2'd3, 2'd0, 2'd1, 2'd0}, '{2'd2, 2'd1, 2'd0, 2'd3}};
    typedef enum logic [2:0] {IDLE, KEYGEN, RND_K2, RND_K1, DONE} sdes_dec_state_t;
    function automatic logic [9:0] sdes_p10(input logic [9:0] k);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[4'(9 - i)] = k[4'(10 - P10_T[i])];
        return r;
    endfunction
    function automatic logic [7:0] sdes_p8(input logic [9:0] k);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[3'(7 - i)] = k[4'(10 - P8_T[i])];
        return r;
    endfunction
    function automatic logic [7:0] sdes_ip(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[3'(7 - i)] = b[3'(8 - IP_T[i])];
        return r;
    endfunction
    function automatic logic [7:0] sdes_ip_inv(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[3'(7 - i)] = b[3'(8 - IPI_T[i])];
        return r;
    endfunction
    function automatic logic [7:0] sdes_ep(input logic [3:0] n);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[3'(7 - i)] = n[2'(4 - EP_T[i])];
        return r;
    endfunction
    function automatic logic [3:0] sdes_p4(input logic [3:0] n);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[2'(3 - i)] = n[2'(4 - P4_T[i])];
        return r;
    endfunction
endpackage

// File: rtl/sdes_fk.sv
// sdes_fk: combinational S-DES round function, returns L xor F(R,K); R passes through untouched
module sdes_fk
    import sdes_pkg::*;
(
    input  logic [3:0] l,
    input  logic [3:0] r,
    input  logic [7:0] k,
    output logic [3:0] l_out
);
    logic [7:0] ep;
    logic [1:0] s0;
    logic [1:0] s1;
    assign ep    = sdes_ep(r) ^ k;
    assign s0    = S0[{ep[7], ep[4]}][{ep[6], ep[5]}];
    assign s1    = S1[{ep[3], ep[0]}][{ep[2], ep[1]}];
    assign l_out = l ^ sdes_p4({s0, s1});
endmodule

// File: rtl/sdes_decrypt_core.sv
// sdes_decrypt_core: iterative S-DES decryptor with subkey generation, key cache and valid/ready handshakes
module sdes_decrypt_core
    import sdes_pkg::*;
#(
    parameter bit KEY_CACHE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_cipher,
    input  logic [9:0] in_key,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_plain
);
    sdes_dec_state_t state;
    logic [3:0] l;
    logic [3:0] r;
    logic [9:0] key;
    logic [7:0] k1;
    logic [7:0] k2;
    logic       cache_valid;
    logic [9:0] p10;
    logic [9:0] ls1;
    logic [9:0] ls3;
    logic [3:0] f_l;
    logic       hit;
    assign in_ready = state == IDLE;
    assign hit      = KEY_CACHE && cache_valid && in_key == key;
    assign p10      = sdes_p10(key);
    assign ls1      = {p10[8:5], p10[9], p10[3:0], p10[4]};
    assign ls3      = {p10[6:5], p10[9:7], p10[1:0], p10[4:2]};
    sdes_fk u_fk (
        .l    (l),
        .r    (r),
        .k    (state == RND_K2 ? k2 : k1),
        .l_out(f_l)
    );
    // FSM stepping the block through keygen, K2 round + swap, K1 round + IP^-1, and output hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            l           <= '0;
            r           <= '0;
            key         <= '0;
            k1          <= '0;
            k2          <= '0;
            cache_valid <= 1'b0;
            out_valid   <= 1'b0;
            out_plain   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    {l, r} <= sdes_ip(in_cipher);
                    key    <= in_key;
                    state  <= hit ? RND_K2 : KEYGEN;
                end
                KEYGEN: begin
                    k1          <= sdes_p8(ls1);
                    k2          <= sdes_p8(ls3);
                    cache_valid <= 1'b1;
                    state       <= RND_K2;
                end
                RND_K2: begin
                    l     <= r;
                    r     <= f_l;
                    state <= RND_K1;
                end
                RND_K1: begin
                    out_plain <= sdes_ip_inv({f_l, r});
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdes_decrypt_core.sv
// tb_sdes_decrypt_core: randomized and directed checks of the S-DES decryptor against a bit-level reference model
module tb_sdes_decrypt_core;
    localparam int P10_T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam int P8_T  [10] = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
    localparam int IP_T  [10] = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
    localparam int IPI_T [10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
    localparam int EP_T  [10] = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
    localparam int P4_T  [10] = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
    localparam int S0_T  [16] = '{1, 0, 3, 2, 3, 2, 1, 0, 0, 2, 1, 3, 3, 1, 3, 2};
    localparam int S1_T  [16] = '{0, 1, 2, 3, 2, 0, 1, 3, 3, 0, 1, 0, 2, 1, 0, 3};
    localparam logic [9:0] K  = 10'b1010000010;
    localparam logic [9:0] KA = 10'h15B;
    localparam logic [9:0] KB = 10'h2C4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_valid0;
    logic       in_ready, in_ready0;
    logic [7:0] in_cipher;
    logic [9:0] in_key;
    logic       out_valid, out_valid0;
    logic       out_ready, out_ready0;
    logic [7:0] out_plain, out_plain0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         rdy_q[$];
    bit         cache_v = 1'b0;
    logic [9:0] cache_k = '0;

    sdes_decrypt_core #(.KEY_CACHE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_cipher(in_cipher), .in_key(in_key), .out_valid(out_valid),
        .out_ready(out_ready), .out_plain(out_plain)
    );
    sdes_decrypt_core #(.KEY_CACHE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_cipher(in_cipher), .in_key(in_key), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_plain(out_plain0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int perm(input int v, input int n, input int m, input int t[10]);
        int res = 0;
        for (int i = 0; i < m; i++) res = (res << 1) | ((v >> (n - t[i])) & 1);
        return res;
    endfunction
    function automatic int rol5(input int x, input int s);
        return ((x << s) | (x >> (5 - s))) & 31;
    endfunction
    function automatic void subkeys(input int key, output int k1, output int k2);
        int p = perm(key, 10, 10, P10_T);
        k1 = perm((rol5(p >> 5, 1) << 5) | rol5(p & 31, 1), 10, 8, P8_T);
        k2 = perm((rol5(p >> 5, 3) << 5) | rol5(p & 31, 3), 10, 8, P8_T);
    endfunction
    function automatic int fk(input int b, input int k);
        int ep = perm(b & 15, 4, 8, EP_T) ^ k;
        int a = ep >> 4;
        int c = ep & 15;
        int s0 = S0_T[(((a >> 2) & 2) | (a & 1)) * 4 + ((a >> 1) & 3)];
        int s1 = S1_T[(((c >> 2) & 2) | (c & 1)) * 4 + ((c >> 1) & 3)];
        return ((((b >> 4) ^ perm((s0 << 2) | s1, 4, 4, P4_T)) & 15) << 4) | (b & 15);
    endfunction
    function automatic int crypt(input int blk, input int key, input bit dec);
        int k1, k2, x;
        subkeys(key, k1, k2);
        x = perm(blk, 8, 8, IP_T);
        x = fk(x, dec ? k2 : k1);
        x = ((x & 15) << 4) | (x >> 4);
        x = fk(x, dec ? k1 : k2);
        return perm(x, 8, 8, IPI_T);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every cycle compare handshake signals and plaintext to the reference model
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            rdy_q.delete();
            cache_v = 1'b0;
        end else begin
            bit ev;
            bit hit;
            chk("in_ready", in_ready, exp_q.size() == 0);
            ev = exp_q.size() > 0 && cyc >= rdy_q[0];
            chk("out_valid", out_valid, ev);
            if (ev) chk("out_plain", out_plain, exp_q[0]);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(rdy_q.pop_front());
            end
            if (in_valid && in_ready) begin
                hit = cache_v && in_key == cache_k;
                exp_q.push_back(8'(crypt(in_cipher, in_key, 1'b1)));
                rdy_q.push_back(cyc + (hit ? 3 : 4));
                cache_v = 1'b1;
                cache_k = in_key;
            end
        end
    end

    task automatic send(input bit sel, input logic [7:0] c, input logic [9:0] k);
        int n = 0;
        bit acc;
        in_cipher = c;
        in_key = k;
        if (sel) in_valid0 = 1'b1; else in_valid = 1'b1;
        do begin
            acc = sel ? in_ready0 : in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        in_valid = 1'b0;
        in_valid0 = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_out(input bit sel, output int lat);
        lat = 1;
        while (!(sel ? out_valid0 : out_valid) && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!(sel ? out_valid0 : out_valid)) chk("out_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, k1, k2, t, n;
        int acc_t[6];
        bit acc;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_valid0 = 1'b0;
        out_ready = 1'b1;
        out_ready0 = 1'b1;
        in_cipher = '0;
        in_key = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        subkeys(K, k1, k2);
        chk("model_k1", k1, 8'hA4);
        chk("model_k2", k2, 8'h43);
        chk("model_dec", crypt(8'h38, K, 1'b1), 8'h97);
        chk("model_enc", crypt(8'h97, K, 1'b0), 8'h38);
        chk("reset_out_plain", out_plain, 8'h00);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);

        send(1'b0, 8'h38, K);
        wait_out(1'b0, lat);
        chk("miss_latency", lat, 4);
        chk("miss_plain", out_plain, 8'h97);
        send(1'b0, 8'h38, K);
        wait_out(1'b0, lat);
        chk("hit_latency", lat, 3);
        chk("hit_plain", out_plain, 8'h97);

        send(1'b1, 8'h38, K);
        wait_out(1'b1, lat);
        chk("nocache_latency_first", lat, 4);
        chk("nocache_plain_first", out_plain0, 8'h97);
        send(1'b1, 8'h38, K);
        wait_out(1'b1, lat);
        chk("nocache_latency_repeat", lat, 4);
        chk("nocache_plain_repeat", out_plain0, 8'h97);

        out_ready = 1'b0;
        send(1'b0, 8'h38, K);
        wait_out(1'b0, lat);
        repeat (10) begin
            in_valid = 1'($urandom);
            in_cipher = 8'($urandom);
            in_key = 10'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("hold_plain", out_plain, 8'h97);
        chk("hold_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        out_ready = 1'b1;

        send(1'b0, 8'h38, K);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_plain", out_plain, 8'h00);
        chk("async_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(1'b0, 8'h38, K);
        wait_out(1'b0, lat);
        chk("post_rst_latency", lat, 4);
        chk("post_rst_plain", out_plain, 8'h97);

        in_valid = 1'b1;
        in_key = KA;
        in_cipher = 8'($urandom);
        t = 0;
        n = 0;
        while (n < 6 && t < 100) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
            if (acc) begin
                acc_t[n] = t;
                n++;
                in_key = n % 2 ? KB : KA;
                in_cipher = 8'($urandom);
            end
        end
        in_valid = 1'b0;
        chk("b2b_accepts", n, 6);
        for (int i = 1; i < 6; i++) chk("b2b_spacing", acc_t[i] - acc_t[i - 1], 5);

        repeat (400) begin
            in_valid = 1'($urandom);
            in_cipher = 8'($urandom);
            case ($urandom_range(2))
                0: in_key = K;
                1: in_key = KA;
                default: in_key = KB;
            endcase
            out_ready = $urandom_range(2) != 0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        for (int kk = 0; kk < 8; kk++) begin
            logic [9:0] key;
            key = 10'($urandom);
            for (int p = 0; p < 256; p++) begin
                send(1'b0, 8'(crypt(p, key, 1'b0)), key);
                wait_out(1'b0, lat);
                chk("roundtrip", out_plain, p);
            end
        end

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
